// File: rtl/power_window_detect_pkg.sv
// power_detect_pkg: shared FSM state enum, sample width MAG_W and sum_w() sum-width helper
package power_detect_pkg;
  localparam int MAG_W = 32;
  typedef enum logic [2:0] {FILL, IDLE, ARMING, ACTIVE, RELEASING} state_t;
  function automatic int sum_w(input int win_log2);
    return MAG_W + win_log2;
  endfunction
endpackage

// File: rtl/power_window_detect_if.sv
// power_window_detect_if: sample/threshold in (mag_sq, mag_sq_strobe, threshold), results out (avg_pwr, avg_strobe, trigger, trigger_rise, peak_pwr); master drives samples, slave is the detector
interface power_window_detect_if;
  import power_detect_pkg::*;
  logic [MAG_W-1:0] mag_sq;
  logic mag_sq_strobe;
  logic [MAG_W-1:0] threshold;
  logic [MAG_W-1:0] avg_pwr;
  logic avg_strobe;
  logic trigger;
  logic trigger_rise;
  logic [MAG_W-1:0] peak_pwr;
  modport master(output mag_sq, mag_sq_strobe, threshold, input avg_pwr, avg_strobe, trigger, trigger_rise, peak_pwr);
  modport slave(input mag_sq, mag_sq_strobe, threshold, output avg_pwr, avg_strobe, trigger, trigger_rise, peak_pwr);
endinterface

// File: rtl/power_window_detect_sample_delay_line.sv
// sample_delay_line: DEPTH x WIDTH shift register (clock, reset, shift_en, din in; oldest out = entry from DEPTH shifts ago)
module sample_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] oldest
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  always_ff @(posedge clock)
    if (reset) mem <= '0;
    else if (shift_en) mem <= {mem[DEPTH-2:0], din};
  assign oldest = mem[DEPTH-1];
endmodule

// File: rtl/power_window_detect.sv
// power_window_detect: sliding-window average of mag_sq with hysteretic trigger FSM (clock, reset, enable, bus slave); peak_pwr tracking under POWER_WINDOW_PEAK_EN
module power_window_detect
  import power_detect_pkg::*;
#(
  parameter int WIN_LOG2 = 4,
  parameter int HOLD_ON  = 3,
  parameter int HOLD_OFF = 16,
  parameter int CNT_W    = 8
) (
  input logic clock,
  input logic reset,
  input logic enable,
  power_window_detect_if.slave bus
);
  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = sum_w(WIN_LOG2);
  logic acc, evt, hit, trig, trig_nx, avg_stb_q, rise_q;
  logic [MAG_W-1:0] oldest, avg_nx, avg_q;
  logic [SW-1:0] sum_q, sum_nx;
  logic [WIN_LOG2-1:0] fill_cnt;
  logic [CNT_W-1:0] on_cnt, on_nx, off_cnt, off_nx;
  state_t state, state_nx;
  sample_delay_line #(.WIDTH(MAG_W), .DEPTH(N)) u_delay (
    .clock(clock),
    .reset(reset),
    .shift_en(acc),
    .din(bus.mag_sq),
    .oldest(oldest)
  );
  assign acc     = enable & bus.mag_sq_strobe;
  assign sum_nx  = sum_q + SW'(bus.mag_sq) - SW'(oldest);
  assign avg_nx  = MAG_W'(sum_nx >> WIN_LOG2);
  // the Nth accepted sample is the first full window, so it already produces an average
  assign evt     = acc & (state != FILL || fill_cnt == WIN_LOG2'(N - 1));
  assign hit     = avg_nx > bus.threshold;
  assign trig    = state == ACTIVE || state == RELEASING;
  assign trig_nx = state_nx == ACTIVE || state_nx == RELEASING;
  always_comb begin
    state_nx = state;
    on_nx    = on_cnt;
    off_nx   = off_cnt;
    if (evt)
      case (state)
        FILL, IDLE: begin
          on_nx    = hit ? CNT_W'(1) : '0;
          state_nx = !hit ? IDLE : HOLD_ON == 1 ? ACTIVE : ARMING;
        end
        ARMING: begin
          on_nx    = hit ? on_cnt + 1'b1 : '0;
          state_nx = !hit ? IDLE : on_nx >= CNT_W'(HOLD_ON) ? ACTIVE : ARMING;
        end
        ACTIVE: begin
          off_nx   = hit ? '0 : CNT_W'(1);
          state_nx = hit ? ACTIVE : HOLD_OFF == 1 ? IDLE : RELEASING;
        end
        RELEASING: begin
          off_nx   = hit ? '0 : off_cnt + 1'b1;
          state_nx = hit ? ACTIVE : off_nx >= CNT_W'(HOLD_OFF) ? IDLE : RELEASING;
        end
        default: state_nx = FILL;
      endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state     <= FILL;
      on_cnt    <= '0;
      off_cnt   <= '0;
      fill_cnt  <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
      avg_stb_q <= 1'b0;
      rise_q    <= 1'b0;
    end else if (enable) begin
      state     <= state_nx;
      on_cnt    <= on_nx;
      off_cnt   <= off_nx;
      avg_stb_q <= evt;
      rise_q    <= evt & trig_nx & !trig;
      if (acc) sum_q <= sum_nx;
      if (acc && state == FILL) fill_cnt <= fill_cnt + 1'b1;
      if (evt) avg_q <= avg_nx;
    end else begin
      avg_stb_q <= 1'b0;
      rise_q    <= 1'b0;
    end
  assign bus.avg_pwr      = avg_q;
  assign bus.avg_strobe   = avg_stb_q & enable;
  assign bus.trigger      = trig;
  assign bus.trigger_rise = rise_q & enable;
`ifdef POWER_WINDOW_PEAK_EN
  logic [MAG_W-1:0] peak_q;
  always_ff @(posedge clock)
    if (reset) peak_q <= '0;
    else if (evt && ((trig_nx && !trig) || (trig && avg_nx > peak_q))) peak_q <= avg_nx;
  assign bus.peak_pwr = peak_q;
`else
  assign bus.peak_pwr = '0;
`endif
endmodule

// File: tb/tb_power_window_detect.sv
// tb_power_window_detect: directed self-checking bench for power_window_detect
module tb_power_window_detect;
  import power_detect_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  int checks = 0;
  int errors = 0;
`ifdef POWER_WINDOW_PEAK_EN
  localparam int PEAK = 100;
`else
  localparam int PEAK = 0;
`endif
  power_window_detect_if bus();
  power_window_detect dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [31:0] m, input logic s);
    bus.mag_sq = m;
    bus.mag_sq_strobe = s;
    @(posedge clock);
    #2;
  endtask
  initial begin
    bus.mag_sq = 0;
    bus.mag_sq_strobe = 0;
    bus.threshold = 50;
    tick(0, 0);
    tick(0, 0);
    reset = 0;
    tick(0, 0);
    chk("rst_avg", bus.avg_pwr, 0);
    chk("rst_strobe", bus.avg_strobe, 0);
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_rise", bus.trigger_rise, 0);
    chk("rst_peak", bus.peak_pwr, 0);
    for (int i = 1; i <= 15; i++) begin
      tick(100, 1);
      chk("fill_strobe", bus.avg_strobe, 0);
    end
    tick(100, 1);
    chk("first_strobe", bus.avg_strobe, 1);
    chk("first_avg", bus.avg_pwr, 100);
    chk("first_trigger", bus.trigger, 0);
    tick(100, 1);
    chk("s17_trigger", bus.trigger, 0);
    chk("s17_rise", bus.trigger_rise, 0);
    tick(100, 1);
    chk("s18_trigger", bus.trigger, 1);
    chk("s18_rise", bus.trigger_rise, 1);
    tick(100, 0);
    chk("rise_one_cycle", bus.trigger_rise, 0);
    chk("idle_strobe", bus.avg_strobe, 0);
    chk("hold_trigger", bus.trigger, 1);
    chk("peak_first", bus.peak_pwr, PEAK);
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1);
      chk("en_strobe", bus.avg_strobe, 0);
      chk("en_avg", bus.avg_pwr, 100);
      chk("en_trigger", bus.trigger, 1);
    end
    enable = 1;
    for (int k = 1; k <= 23; k++) begin
      tick(0, 1);
      chk("rel_strobe", bus.avg_strobe, 1);
      chk("rel_avg", bus.avg_pwr, k < 16 ? (100 * (16 - k)) >> 4 : 0);
      chk("rel_trigger", bus.trigger, k < 23);
    end
    for (int j = 1; j <= 16; j++) begin
      tick(100, 1);
      chk("ramp_avg", bus.avg_pwr, (100 * j) >> 4);
      chk("ramp_trigger", bus.trigger, j >= 11);
      chk("ramp_rise", bus.trigger_rise, j == 11);
    end
    chk("peak_ramp", bus.peak_pwr, PEAK);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1);
      chk("hy_avg", bus.avg_pwr, (100 * (16 - k)) >> 4);
      chk("hy_trigger", bus.trigger, 1);
    end
    tick(1000, 1);
    chk("hy_bump_avg", bus.avg_pwr, 93);
    chk("hy_bump_trigger", bus.trigger, 1);
    for (int m = 1; m <= 31; m++) begin
      tick(0, 1);
      chk("hy2_avg", bus.avg_pwr, m <= 5 ? (1500 - 100 * m) >> 4 : m <= 15 ? 62 : 0);
      chk("hy2_trigger", bus.trigger, m < 31);
      chk("hy2_rise", bus.trigger_rise, 0);
    end
    chk("peak_hold", bus.peak_pwr, PEAK);
    for (int j = 1; j <= 11; j++) tick(100, 1);
    chk("re_trigger", bus.trigger, 1);
    reset = 1;
    tick(100, 1);
    chk("mid_rst_trigger", bus.trigger, 0);
    chk("mid_rst_avg", bus.avg_pwr, 0);
    chk("mid_rst_strobe", bus.avg_strobe, 0);
    chk("mid_rst_peak", bus.peak_pwr, 0);
    reset = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(100, 1);
      chk("refill_strobe", bus.avg_strobe, 0);
    end
    tick(100, 1);
    chk("refill_first_strobe", bus.avg_strobe, 1);
    chk("refill_avg", bus.avg_pwr, 100);
    chk("refill_trigger", bus.trigger, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/power_window_detect.md
Name: power_window_detect

Overview:
- Downstream consumer of the magnitude-squared stage (32-bit |x|^2 with strobe).
- Keeps a sliding-window sum of the last 2^WIN_LOG2 samples and outputs the window average.
- Drives a hysteretic power trigger FSM, which the packet-detect / sync front-end uses to gate expensive correlators.

Parameters:
- WIN_LOG2, 4: log2 of window length N (N=16 by default); legal range 1..8.
- HOLD_ON, 3: consecutive above-threshold averages required to assert trigger; must be >=1.
- HOLD_OFF, 16: consecutive at-or-below-threshold averages required to release trigger; must be >=1.
- CNT_W, 8: width of the hold counters; must hold max(HOLD_ON, HOLD_OFF).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset (see Interface rule).
- enable  in  1  global clock-enable; low freezes all state.
- mag_sq  in  32  unsigned |x|^2 sample.
- mag_sq_strobe  in  1  mag_sq valid.
- threshold  in  32  unsigned average-power threshold, sampled on every compare.
- avg_pwr  out  32  window average = window sum >> WIN_LOG2.
- avg_strobe  out  1  avg_pwr valid (one cycle).
- trigger  out  1  level; high while power is detected.
- trigger_rise  out  1  one-cycle pulse when trigger goes 0->1.
- peak_pwr  out  32  see Optional Feature.

Behaviour:
- Interface rule: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - avg_pwr=0, avg_strobe=0, trigger=0, trigger_rise=0, peak_pwr=0.
  - Window sum, delay line and fill counter cleared to 0; FSM to FILL.
- Reset mid-operation discards window contents; refill is required.
- enable=0:
  - No state changes; avg_pwr, trigger and peak_pwr hold.
  - avg_strobe and trigger_rise forced 0.
  - A mag_sq_strobe arriving while enable=0 is dropped.
- Delay line:
  - N x 32-bit shift register, advanced only on accepted strobes.
  - Oldest entry is the sample from N strobes ago; zero during fill.
- Sum:
  - Width 32+WIN_LOG2, unsigned, never overflows.
  - On each accepted strobe: sum <= sum + mag_sq - oldest.
- Output timing: avg_pwr and avg_strobe are registered, 1 cycle after the accepted strobe.
- Fill: avg_strobe is suppressed for the first N-1 accepted strobes; the first avg_strobe follows the Nth sample.
- FSM states: FILL, IDLE, ARMING, ACTIVE, RELEASING. Each compare happens on the internal avg-valid event, using avg > threshold (strict).
  - FILL -> IDLE: after N samples.
  - IDLE: if above, on_cnt=1; if HOLD_ON==1, go ACTIVE, else go ARMING.
  - ARMING: if above, on_cnt++; when on_cnt reaches HOLD_ON, go ACTIVE. If not above, go IDLE with on_cnt=0.
  - ACTIVE: trigger=1. If not above, off_cnt=1; if HOLD_OFF==1, go IDLE, else go RELEASING.
  - RELEASING: trigger stays 1. If not above, off_cnt++; when off_cnt reaches HOLD_OFF, go IDLE and set trigger=0. If above, go ACTIVE with off_cnt=0.
- trigger and trigger_rise update in the same cycle as the avg_strobe that causes the change.
- Equal to threshold counts as below.
- Back-to-back strobes every cycle are fully supported, with no throughput loss.

Optional Feature:
- Macro: POWER_WINDOW_PEAK_EN.
- Defined:
  - peak_pwr tracks the maximum avg_pwr seen since the last trigger_rise.
  - On the trigger_rise cycle it loads the current avg.
  - It updates only while trigger=1 and holds after release.
- Undefined: peak_pwr is tied to 0 and no comparator is built.

Decomposition:
- Package power_detect_pkg holds:
  - FSM state enum (FILL, IDLE, ARMING, ACTIVE, RELEASING).
  - MAG_W=32.
  - Function returning sum width (MAG_W+WIN_LOG2).
- One sub-module, sample_delay_line:
  - Parameterized width and depth.
  - Enable-gated shift, exposing the oldest entry.
  - Synchronous clear on reset.

Test Plan:
- Fill timing: mag_sq=100 on every cycle, threshold=50 -> no avg_strobe for samples 1..15; first avg_strobe 1 cycle after sample 16 with avg_pwr=100.
- Trigger assert: same stimulus -> trigger and trigger_rise go high on the avg_strobe for sample 18 (3rd above); trigger_rise lasts 1 cycle.
- Release: after trigger, feed mag_sq=0.
  - avg falls 93,87,81,75,68,62,56,50,...
  - First at-or-below value is 50 at the 8th zero sample.
  - trigger drops on the 23rd zero sample (HOLD_OFF=16).
- Hysteresis reset: while RELEASING, insert one window pushing avg>threshold -> off_cnt clears; trigger stays high for 16 more below-threshold averages.
- Enable/reset: drop enable for 5 cycles with strobes present -> no state change, no strobes. Pulse reset while ACTIVE -> trigger=0 next cycle; 16 new samples are needed before the next avg_strobe.
- Peak (POWER_WINDOW_PEAK_EN): ramp mag_sq 0->1000 then back down while triggered -> peak_pwr equals the max avg_pwr observed; undefined build -> peak_pwr=0 throughout.
